// File: rtl/debug_dump_pkg.sv
// Shared types and constants for the debug dump sequencer.
// DEBUG_DUMP_HEADER_EN adds the HDR state for the 4-byte dump header.
package debug_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_SEND,
`ifdef DEBUG_DUMP_HEADER_EN
        S_HDR,
`endif
        S_DONE
    } state_t;

    localparam logic [1:0] SRC_IMEM = 2'b10;
    localparam logic [1:0] SRC_DMEM = 2'b11;
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    function automatic logic [2:0] bytes_per_word(input logic [1:0] src);
        return (src == SRC_IMEM) ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Up to 4-byte load buffer drained MSB first over a valid/ready stream.
// Outputs decode only registers, so ready never reaches them combinationally.
module dump_byte_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_n,
    input  logic        ready,
    output logic        valid,
    output logic [7:0]  data,
    output logic        last
);

    logic [31:0] buffer;
    logic [2:0]  left;

    assign valid = (left != 3'd0);
    assign last  = (left == 3'd1);
    assign data  = buffer[31:24];

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer <= '0;
            left   <= '0;
        end else if (load) begin
            buffer <= load_data;
            left   <= load_n;
        end else if (valid && ready) begin
            buffer <= {buffer[23:0], 8'h00};
            left   <= left - 3'd1;
        end
    end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Walks one debug read port over an address range and streams the words as bytes.
// DEBUG_DUMP_HEADER_EN prefixes each dump with a 4-byte header.
module debug_dump_sequencer #(
    parameter int DATA_W     = 8,
    parameter int INST_W     = 16,
    parameter int D_ADDR_W   = 12,
    parameter int I_ADDR_W   = 12,
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          src_sel,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                done,
    output logic                debug_enable,
    output logic [3:0]          reg_debug_addr,
    output logic [D_ADDR_W-1:0] dmem_debug_addr,
    output logic [I_ADDR_W-1:0] imem_debug_addr,
    input  logic [DATA_W-1:0]   reg_debug_rdata,
    input  logic [DATA_W-1:0]   dmem_debug_rdata,
    input  logic [INST_W-1:0]   imem_debug_rdata,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);
    import debug_dump_pkg::*;

    localparam logic [7:0] WAIT_LAST = 8'(RD_LATENCY - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     left;
    logic [1:0]          src;
    logic [7:0]          wait_cnt;
    logic                ser_load;
    logic [31:0]         ser_data;
    logic [2:0]          ser_n;
    logic                ser_last;
    logic                byte_done;
    logic [DATA_W-1:0]   word8;

    assign debug_enable = busy;
    assign byte_done    = tx_valid && tx_ready && ser_last;
    assign word8        = (src == SRC_DMEM) ? dmem_debug_rdata : reg_debug_rdata;

    always_comb begin
        ser_load = 1'b0;
        ser_data = '0;
        ser_n    = '0;
        if (state == S_LOAD) begin
            ser_load = 1'b1;
            ser_n    = bytes_per_word(src);
            if (src == SRC_IMEM)
                ser_data = {imem_debug_rdata, {(32-INST_W){1'b0}}};
            else
                ser_data = {word8, {(32-DATA_W){1'b0}}};
        end
`ifdef DEBUG_DUMP_HEADER_EN
        // Header is loaded on the accepting edge, straight from the inputs.
        if (state == S_IDLE && start) begin
            ser_load = 1'b1;
            ser_n    = 3'd4;
            ser_data = {HDR_SYNC, 6'b0, src_sel, 4'b0,
                        base_addr[11:8], base_addr[7:0]};
        end
`endif
    end

    dump_byte_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ser_data),
        .load_n    (ser_n),
        .ready     (tx_ready),
        .valid     (tx_valid),
        .data      (tx_data),
        .last      (ser_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            addr            <= '0;
            left            <= '0;
            src             <= '0;
            wait_cnt        <= '0;
            reg_debug_addr  <= '0;
            dmem_debug_addr <= '0;
            imem_debug_addr <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    src  <= src_sel;
                    addr <= base_addr;
                    left <= count;
                    busy <= 1'b1;
`ifdef DEBUG_DUMP_HEADER_EN
                    state <= S_HDR;
`else
                    if (count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ADDR;
                    end
`endif
                end
`ifdef DEBUG_DUMP_HEADER_EN
                S_HDR: if (byte_done) begin
                    if (left == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ADDR;
                    end
                end
`endif
                S_ADDR: begin
                    reg_debug_addr  <= addr[3:0];
                    dmem_debug_addr <= addr[D_ADDR_W-1:0];
                    imem_debug_addr <= addr[I_ADDR_W-1:0];
                    wait_cnt        <= '0;
                    state           <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST)
                        state <= S_LOAD;
                    else
                        wait_cnt <= wait_cnt + 8'd1;
                end
                S_LOAD: state <= S_SEND;
                S_SEND: if (byte_done) begin
                    if (left == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        left  <= left - 1'b1;
                        addr  <= addr + 1'b1;
                        state <= S_ADDR;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer: reference byte stream per dump.
// Honours DEBUG_DUMP_HEADER_EN when the design is built with it.
module tb_debug_dump_sequencer;

    localparam int RD_LAT = 1;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] a;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  src_sel = '0;
    logic [11:0] base_addr = '0;
    logic [12:0] count = '0;
    logic        busy, done, debug_enable;
    logic [3:0]  reg_debug_addr;
    logic [11:0] dmem_debug_addr, imem_debug_addr;
    logic [7:0]  reg_debug_rdata = '0;
    logic [7:0]  dmem_debug_rdata = '0;
    logic [15:0] imem_debug_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    debug_dump_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .src_sel          (src_sel),
        .base_addr        (base_addr),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .debug_enable     (debug_enable),
        .reg_debug_addr   (reg_debug_addr),
        .dmem_debug_addr  (dmem_debug_addr),
        .imem_debug_addr  (imem_debug_addr),
        .reg_debug_rdata  (reg_debug_rdata),
        .dmem_debug_rdata (dmem_debug_rdata),
        .imem_debug_rdata (imem_debug_rdata),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: a keyed function of the address, one-cycle read.
    logic [7:0]  rkey = '0, dkey = '0;
    logic [15:0] ikey = '0;
    always @(posedge clk) begin
        reg_debug_rdata  <= {4'h5, reg_debug_addr} ^ rkey;
        dmem_debug_rdata <= dmem_debug_addr[7:0] ^ dkey;
        imem_debug_rdata <= {4'hC, imem_debug_addr} ^ ikey;
    end

    int rdy_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 9) < 7);
            default: tx_ready = 1'b0;
        endcase
    end

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   exp_done = 0, done_seen = 0, last_hs_cyc = 0;
    bit   hs_since_done = 0, stall_prev = 0;
    logic [7:0] stall_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!tx_valid || tx_data != stall_data) begin
                    errors++;
                    $display("FAIL stall_hold valid=%0b data=%02h want 1/%02h",
                             tx_valid, tx_data, stall_data);
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte got=%02h want none", tx_data);
                end else if (tx_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (tx_data != e.b || (e.chk &&
                        (dmem_debug_addr != e.a || imem_debug_addr != e.a ||
                         reg_debug_addr != e.a[3:0]))) begin
                        errors++;
                        $display("FAIL byte got=%02h d=%03h i=%03h r=%h want=%02h a=%03h",
                                 tx_data, dmem_debug_addr, imem_debug_addr,
                                 reg_debug_addr, e.b, e.a);
                    end
                    last_hs_cyc   = cyc;
                    hs_since_done = 1;
                end
            end
            if (done) begin
                checks++;
                if (exp_done == 0 || exp_q.size() != 0 ||
                    (hs_since_done && cyc != last_hs_cyc + 1)) begin
                    errors++;
                    $display("FAIL done_pulse pending=%0d left=%0d cyc=%0d want cyc=%0d",
                             exp_done, exp_q.size(), cyc, last_hs_cyc + 1);
                end
                if (exp_done > 0) exp_done--;
                done_seen++;
                hs_since_done = 0;
            end
        end
    end

    function automatic void push_b(logic [7:0] b, logic [11:0] a, bit chk);
        exp_t e;
        e.b = b;
        e.a = a;
        e.chk = chk;
        exp_q.push_back(e);
    endfunction

    function automatic void push_expected(logic [1:0] s, logic [11:0] b,
                                          logic [12:0] c);
        logic [11:0] a;
        logic [15:0] w;
`ifdef DEBUG_DUMP_HEADER_EN
        push_b(8'hA5, '0, 0);
        push_b({6'b0, s}, '0, 0);
        push_b({4'b0, b[11:8]}, '0, 0);
        push_b(b[7:0], '0, 0);
`endif
        for (int i = 0; i < int'(c); i++) begin
            a = b + 12'(i);
            if (s == 2'b10) begin
                w = {4'hC, a} ^ ikey;
                push_b(w[15:8], a, 1);
                push_b(w[7:0], a, 1);
            end else if (s == 2'b11) begin
                push_b(a[7:0] ^ dkey, a, 1);
            end else begin
                push_b({4'h5, a[3:0]} ^ rkey, a, 1);
            end
        end
    endfunction

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    task automatic run_dump(input logic [1:0] s, input logic [11:0] b,
                            input logic [12:0] c, input bit bstart,
                            input bit stall);
        int s0, target, lat, want_lat, saved;
        bit seen;
        logic [7:0] hold;
        wait_idle();
        saved = rdy_mode;
        if (stall) rdy_mode = 2;
        push_expected(s, b, c);
        exp_done++;
        target = done_seen + 1;
        @(posedge clk);
        #1;
        src_sel = s;
        base_addr = b;
        count = c;
        start = 1'b1;
        s0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_sel = 2'($urandom);
        base_addr = 12'($urandom);
        count = 13'($urandom);
        @(negedge clk);
        checks++;
        if (!busy || !debug_enable) begin
            errors++;
            $display("FAIL busy_on busy=%0b en=%0b want 1/1", busy, debug_enable);
        end
`ifdef DEBUG_DUMP_HEADER_EN
        want_lat = 1;
`else
        want_lat = 3 + RD_LAT;
        if (c == 0) begin
            checks++;
            if (!done || tx_valid) begin
                errors++;
                $display("FAIL count0 done=%0b valid=%0b want 1/0", done, tx_valid);
            end
        end
`endif
        if (exp_q.size() != 0) begin
            seen = 0;
            for (int k = 0; k < 200; k++) begin
                if (tx_valid) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            lat = cyc - s0;
            checks++;
            if (!seen || lat != want_lat) begin
                errors++;
                $display("FAIL first_valid seen=%0b lat=%0d want %0d",
                         seen, lat, want_lat);
            end
            if (stall) begin
                hold = tx_data;
                repeat (20) @(negedge clk);
                checks++;
                if (!tx_valid || tx_data != hold) begin
                    errors++;
                    $display("FAIL stall_end valid=%0b data=%02h want 1/%02h",
                             tx_valid, tx_data, hold);
                end
                rdy_mode = saved;
            end
            if (bstart) begin
                @(posedge clk);
                #1;
                start = 1'b1;
                src_sel = 2'($urandom);
                base_addr = 12'($urandom);
                count = 13'($urandom_range(1, 5));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        seen = 0;
        for (int k = 0; k < 5000; k++) begin
            if (done_seen >= target) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout seen=%0d want %0d", done_seen, target);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [1:0]  s;
        logic [11:0] b;
        logic [12:0] c;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy || done || debug_enable || tx_valid || tx_data != 8'h00 ||
            reg_debug_addr != 4'h0 || dmem_debug_addr != 12'h0 ||
            imem_debug_addr != 12'h0) begin
            errors++;
            $display("FAIL reset_state b=%0b d=%0b v=%0b data=%02h want zeros",
                     busy, done, tx_valid, tx_data);
        end

        rdy_mode = 0;
        run_dump(2'b11, 12'h010, 13'd3, 0, 0);
        run_dump(2'b10, 12'h000, 13'd2, 0, 0);
        run_dump(2'b00, 12'hFFE, 13'd4, 0, 0);
        run_dump(2'b11, 12'hFFE, 13'd4, 0, 0);
        run_dump(2'b11, 12'h100, 13'd3, 0, 1);
        run_dump(2'b11, 12'h123, 13'd0, 0, 0);
        run_dump(2'b10, 12'h7F0, 13'd5, 1, 0);
        run_dump(2'b01, 12'hFF0, 13'd20, 0, 0);

        rdy_mode = 1;
        for (int n = 0; n < 25; n++) begin
            s = 2'($urandom);
            b = 12'($urandom);
            c = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(20, 40))
                                            : 13'($urandom_range(0, 6));
            rkey = 8'($urandom);
            dkey = 8'($urandom);
            ikey = 16'($urandom);
            run_dump(s, b, c, (c >= 4) && ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of a stalled byte.
        wait_idle();
        rdy_mode = 2;
        push_expected(2'b11, 12'h200, 13'd3);
        @(posedge clk);
        #1;
        src_sel = 2'b11;
        base_addr = 12'h200;
        count = 13'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_valid) break;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        hs_since_done = 0;
        rdy_mode = 0;
        @(negedge clk);
        checks++;
        if (tx_valid || busy || done) begin
            errors++;
            $display("FAIL mid_reset v=%0b b=%0b d=%0b want 0/0/0",
                     tx_valid, busy, done);
        end
        repeat (10) @(negedge clk);

        rkey = 8'h00;
        dkey = 8'h3C;
        ikey = 16'h0000;
        run_dump(2'b11, 12'h0FE, 13'd3, 0, 0);
        repeat (5) @(negedge clk);

        checks++;
        if (exp_q.size() != 0 || exp_done != 0) begin
            errors++;
            $display("FAIL leftover bytes=%0d dones=%0d want 0/0",
                     exp_q.size(), exp_done);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
